// File: rtl/testeio_pio_in_capture.sv
`default_nettype none
// ============================================================================
//  Module      : testeio_pio_in_capture
//  Description : Avalon-MM parallel input port with a configurable-depth
//                input synchronizer, per-bit edge capture and a level
//                interrupt.
//
//                Register map (word address):
//                  0 data        (RO)   synchronized in_port
//                  1 irqmask     (RW)   WIDTH bits
//                  2 reserved           reads 0, writes ignored
//                  3 edgecapture (R/W1C) sticky per-bit edge flags
//
//  Ports       : clk        - single clock, rising edge
//                reset_n    - asynchronous active-low reset
//                address    - slave word address
//                chipselect - slave select, qualifies writes
//                write_n    - active-low write strobe
//                writedata  - write data (bits [WIDTH-1:0] used)
//                in_port    - asynchronous external inputs
//                readdata   - registered read data, one-cycle latency
//                irq        - level interrupt, |(edgecapture & irqmask)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module testeio_pio_in_capture #(
    parameter int WIDTH       = 8,   // 1..32
    parameter int EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
    parameter int SYNC_STAGES = 2    // 2..4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               c_ARM_W    = $clog2(SYNC_STAGES + 2);
    // Counter saturates once the synchronizer and prev are both flushed with
    // post-reset samples, so a level present at reset release never looks
    // like an edge.
    localparam logic [c_ARM_W-1:0] c_ARM_DONE = c_ARM_W'(SYNC_STAGES + 1);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd1;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_irqmask;
    logic [WIDTH-1:0]                  r_edgecapture;
    logic [c_ARM_W-1:0]                r_arm_cnt;
    logic [31:0]                       r_readdata;

    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edges;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_armed;
    logic [31:0]      w_rd_next;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_wdata    = writedata[WIDTH-1:0];
    assign w_wr       = chipselect & ~write_n;
    assign w_armed    = (r_arm_cnt == c_ARM_DONE);

    // Upper write-data bits are intentionally ignored for narrow ports.
    generate
        if (WIDTH < 32) begin : g_wdata_pad
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = |writedata[31:WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronizer and one-clock delayed copy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_sync_out;
        end
    end

    // ------------------------------------------------------------------
    // Arm counter: counts up after reset release, then sticks
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge_raw = w_sync_out & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_raw = ~w_sync_out & r_prev;
        end else begin : g_edge_any
            assign w_edge_raw = w_sync_out ^ r_prev;
        end
    endgenerate

    assign w_edges = w_armed ? w_edge_raw : '0;

    // ------------------------------------------------------------------
    // Registers: irqmask and edgecapture
    // ------------------------------------------------------------------
    assign w_clr = (w_wr && (address == c_ADDR_EDGE)) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask     <= '0;
            r_edgecapture <= '0;
        end else begin
            if (w_wr && (address == c_ADDR_MASK)) begin
                r_irqmask <= w_wdata;
            end
            // Set is OR-ed in after the clear so a same-cycle edge wins.
            r_edgecapture <= (r_edgecapture & ~w_clr) | w_edges;
        end
    end

    // ------------------------------------------------------------------
    // Read path: registered every clock regardless of chipselect
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_next = '0;
        case (address)
            c_ADDR_DATA: w_rd_next[WIDTH-1:0] = w_sync_out;
            c_ADDR_MASK: w_rd_next[WIDTH-1:0] = r_irqmask;
            c_ADDR_EDGE: w_rd_next[WIDTH-1:0] = r_edgecapture;
            default:     w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_next;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecapture & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_testeio_pio_in_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_testeio_pio_in_capture
//  Description : Self-checking bench for testeio_pio_in_capture
//                (WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2). A history-based
//                reference model predicts readdata and irq every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_testeio_pio_in_capture;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  h [0:4095];   // in_port value sampled at edge n after release
    int          n;            // edges since reset release
    logic [7:0]  m_ec;
    logic [7:0]  m_mask;
    logic [31:0] m_rd;

    testeio_pio_in_capture #(
        .WIDTH       (8),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hist(input int j);
        return (j < 1) ? 8'h00 : h[j];
    endfunction

    // One bus cycle: drive at the falling edge, update the model at the
    // rising edge, compare at the next falling edge.
    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [7:0] inp);
        logic [7:0] edges;
        logic       wr;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        n++;
        wr = cs && !wn;
        // Two-stage sync: sync_out before edge n is the sample from edge n-2,
        // prev is the one from edge n-3. Detection is live from edge 4 on.
        edges = (n >= 4) ? (hist(n-2) & ~hist(n-3)) : 8'h00;
        case (a)
            2'd0:    m_rd = {24'h0, hist(n-2)};
            2'd1:    m_rd = {24'h0, m_mask};
            2'd3:    m_rd = {24'h0, m_ec};
            default: m_rd = 32'h0;
        endcase
        if (wr && a == 2'd3) m_ec = m_ec & ~wd[7:0];
        m_ec = m_ec | edges;
        if (wr && a == 2'd1) m_mask = wd[7:0];
        h[n] = inp;
        @(negedge clk);
        check("model_readdata", readdata, m_rd);
        check("model_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
    endtask

    task automatic idle(input logic [1:0] a, input logic [7:0] inp);
        step(a, 1'b1, 1'b1, 32'h0, inp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [7:0] inp);
        step(a, 1'b1, 1'b0, d, inp);
    endtask

    // Asynchronous reset mid-cycle, checked before the next rising edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        n      = 0;
        m_ec   = 8'h00;
        m_mask = 8'h00;
        m_rd   = 32'h0;
    endtask

    initial begin
        logic [7:0] cur;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        n          = 0;
        m_ec       = 8'h00;
        m_mask     = 8'h00;
        m_rd       = 32'h0;

        // Reset state, with in_port already high
        @(negedge clk);
        @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // Arming: level held through release must not capture
        repeat (6) idle(2'd3, 8'hFF);
        check("arm_edgecapture", readdata, 32'h0);
        check("arm_irq", {31'b0, irq}, 32'h0);

        // Read path
        repeat (5) idle(2'd0, 8'hA5);
        check("data_read", readdata, 32'h0000_00A5);

        // Rising edge on bit 0 with irq
        wr(2'd1, 32'h1, 8'hA4);
        repeat (3) idle(2'd3, 8'hA4);
        idle(2'd3, 8'hA5);                          // edge k
        idle(2'd3, 8'hA5);                          // edge k+1
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        idle(2'd3, 8'hA5);                          // edge k+2
        check("irq_set", {31'b0, irq}, 32'h1);
        idle(2'd3, 8'hA5);
        check("ec_bit0", readdata, 32'h1);
        wr(2'd3, 32'h1, 8'hA5);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        idle(2'd3, 8'hA5);
        check("ec_cleared", readdata, 32'h0);

        // Set/clear collision on bit 3
        idle(2'd3, 8'hAD);                          // edge k
        idle(2'd3, 8'hAD);                          // edge k+1
        wr(2'd3, 32'h8, 8'hAD);                     // edge k+2: set and clear
        idle(2'd3, 8'hAD);
        check("collision_set_wins", readdata, 32'h8);

        // Masking, reserved address, chipselect qualification
        wr(2'd3, 32'hFF, 8'hAD);
        wr(2'd1, 32'h0, 8'hAD);
        repeat (3) idle(2'd3, 8'hBD);
        idle(2'd3, 8'hBD);
        check("ec_bit4", readdata, 32'h10);
        check("masked_irq", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'hFFFF_FFFF, 8'hBD);
        idle(2'd2, 8'hBD);
        check("reserved_read", readdata, 32'h0);
        idle(2'd3, 8'hBD);
        check("reserved_no_effect", readdata, 32'h10);
        step(2'd1, 1'b0, 1'b0, 32'hFF, 8'hBD);
        idle(2'd1, 8'hBD);
        check("nocs_mask", readdata, 32'h0);
        step(2'd3, 1'b0, 1'b0, 32'h10, 8'hBD);
        idle(2'd3, 8'hBD);
        check("nocs_ec", readdata, 32'h10);

        // Randomized traffic against the model
        cur = 8'hBD;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) cur = 8'($urandom);
            step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, cur);
        end

        // Mid-operation reset with everything set
        wr(2'd1, 32'hFF, 8'h00);
        repeat (4) idle(2'd3, 8'h00);
        wr(2'd3, 32'hFF, 8'h00);
        repeat (4) idle(2'd3, 8'hFF);
        idle(2'd3, 8'hFF);
        check("pre_reset_ec", readdata, 32'hFF);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        do_reset();
        idle(2'd1, 8'hFF);
        check("post_reset_mask", readdata, 32'h0);
        repeat (5) idle(2'd3, 8'hFF);
        check("post_reset_ec", readdata, 32'h0);
        check("post_reset_irq", {31'b0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
